// File: rtl/crd_drop_unit_pkg.sv
// Shared token encoding, widths and FSM state type for the coordinate drop unit.
package crd_drop_unit_pkg;

  localparam int unsigned TOKEN_W  = 17;
  localparam int unsigned CTRL_BIT = 16;
  localparam int unsigned VALUE_W  = 16;
  localparam int unsigned LEVEL_W  = 8;
  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

  typedef struct packed {
    logic               ctrl;
    logic [VALUE_W-1:0] value;
  } token_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_done(input token_t tok);
    return tok == token_t'(DONE_TOKEN);
  endfunction

  function automatic logic [LEVEL_W-1:0] stop_level(input token_t tok);
    return tok.value[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/crd_drop_unit_reg_fifo_2.sv
// Two-entry registered ready/valid FIFO used to buffer each output stream.
module reg_fifo_2 #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = en && in_valid && in_ready;
  assign pop       = en && out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/crd_drop_unit.sv
// Drops outer coordinates whose inner fiber is empty; inner stream passes through.
module crd_drop_unit
  import crd_drop_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_en,
  input  logic               flush,
  input  logic               tile_en,
  input  logic [TOKEN_W-1:0] crd_in_outer,
  input  logic               crd_in_outer_valid,
  output logic               crd_in_outer_ready,
  input  logic [TOKEN_W-1:0] crd_in_inner,
  input  logic               crd_in_inner_valid,
  output logic               crd_in_inner_ready,
  output logic [TOKEN_W-1:0] crd_out_outer,
  output logic               crd_out_outer_valid,
  input  logic               crd_out_outer_ready,
  output logic [TOKEN_W-1:0] crd_out_inner,
  output logic               crd_out_inner_valid,
  input  logic               crd_out_inner_ready
);

  state_e state, state_d;
  logic   nonempty, nonempty_d;
  token_t o_tok, i_tok;
  logic   active, clear;
  logic   o_space, i_space;
  logic   outer_rdy, inner_rdy;
  logic   o_xfer, i_xfer, push_o;
  logic   of_valid, if_valid;

  assign o_tok  = token_t'(crd_in_outer);
  assign i_tok  = token_t'(crd_in_inner);
  assign clear  = rst || flush;
  assign active = clk_en && tile_en && !clear && (state != ST_DONE);

  assign o_xfer = crd_in_outer_valid && outer_rdy;
  assign i_xfer = crd_in_inner_valid && inner_rdy;
  // Outer data is kept only when its inner fiber carried data; controls always pass.
  assign push_o = o_xfer && (o_tok.ctrl || nonempty);

  assign crd_in_outer_ready = outer_rdy;
  assign crd_in_inner_ready = inner_rdy;

  always_ff @(posedge clk) begin
    if (clear) begin
      state    <= ST_IDLE;
      nonempty <= 1'b0;
    end else if (clk_en) begin
      state    <= state_d;
      nonempty <= nonempty_d;
    end
  end

  always_comb begin
    outer_rdy  = 1'b0;
    inner_rdy  = 1'b0;
    nonempty_d = nonempty;
    state_d    = state;

    // Input handshakes: outer head steers whether the inner side may move.
    if (active) begin
      if (!crd_in_outer_valid) begin
        outer_rdy = o_space;
      end else if (is_done(o_tok)) begin
        if (crd_in_inner_valid && is_done(i_tok) && o_space && i_space) begin
          outer_rdy = 1'b1;
          inner_rdy = 1'b1;
        end
      end else if (o_tok.ctrl) begin
        outer_rdy = o_space;
      end else if (!crd_in_inner_valid || !i_tok.ctrl) begin
        inner_rdy = i_space;
      end else if (!is_done(i_tok)) begin
        inner_rdy = i_space && (o_space || !nonempty);
        outer_rdy = inner_rdy;
      end
    end

    if (i_xfer) nonempty_d = !i_tok.ctrl;

    case (state)
      ST_IDLE: begin
        if (o_xfer && is_done(o_tok)) state_d = ST_DONE;
        else if (active && (crd_in_outer_valid || crd_in_inner_valid)) state_d = ST_PROC;
      end
      ST_PROC: begin
        if (o_xfer && is_done(o_tok)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!of_valid && !if_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  reg_fifo_2 #(.W(TOKEN_W)) u_fifo_outer (
    .clk       (clk),
    .rst       (clear),
    .en        (clk_en),
    .in_data   (crd_in_outer),
    .in_valid  (push_o),
    .in_ready  (o_space),
    .out_data  (crd_out_outer),
    .out_valid (of_valid),
    .out_ready (crd_out_outer_ready && tile_en)
  );

  reg_fifo_2 #(.W(TOKEN_W)) u_fifo_inner (
    .clk       (clk),
    .rst       (clear),
    .en        (clk_en),
    .in_data   (crd_in_inner),
    .in_valid  (i_xfer),
    .in_ready  (i_space),
    .out_data  (crd_out_inner),
    .out_valid (if_valid),
    .out_ready (crd_out_inner_ready && tile_en)
  );

  assign crd_out_outer_valid = of_valid && tile_en && clk_en;
  assign crd_out_inner_valid = if_valid && tile_en && clk_en;

endmodule

// File: tb/tb_crd_drop_unit.sv
// Scoreboard bench for crd_drop_unit: list-level reference model, checks on output transfers.
module tb_crd_drop_unit;

  localparam logic [16:0] S0   = 17'h10000;
  localparam logic [16:0] S1   = 17'h10001;
  localparam logic [16:0] DONE = 17'h10100;

  logic        clk = 1'b0;
  logic        rst, clk_en, flush, tile_en;
  logic [16:0] crd_in_outer, crd_in_inner, crd_out_outer, crd_out_inner;
  logic        crd_in_outer_valid, crd_in_outer_ready, crd_in_inner_valid, crd_in_inner_ready;
  logic        crd_out_outer_valid, crd_out_outer_ready, crd_out_inner_valid, crd_out_inner_ready;

  crd_drop_unit dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .crd_in_outer(crd_in_outer), .crd_in_outer_valid(crd_in_outer_valid), .crd_in_outer_ready(crd_in_outer_ready),
    .crd_in_inner(crd_in_inner), .crd_in_inner_valid(crd_in_inner_valid), .crd_in_inner_ready(crd_in_inner_ready),
    .crd_out_outer(crd_out_outer), .crd_out_outer_valid(crd_out_outer_valid), .crd_out_outer_ready(crd_out_outer_ready),
    .crd_out_inner(crd_out_inner), .crd_out_inner_valid(crd_out_inner_valid), .crd_out_inner_ready(crd_out_inner_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [16:0] src_o[$], src_i[$], exp_o[$], exp_i[$];
  int done_cyc_o, done_cyc_i, first_in_i, first_out_i, bubbles_i, early_done, xfers, last_cycles;

  // Reference model: inner passes through; outer data survives only if its fiber had data.
  task automatic build_expected();
    int ip;
    bit ne;
    exp_i = src_i;
    exp_o = {};
    ip = 0;
    foreach (src_o[k]) begin
      if (src_o[k][16]) exp_o.push_back(src_o[k]);
      else begin
        ne = 1'b0;
        while (ip < src_i.size() && !src_i[ip][16]) begin ne = 1'b1; ip++; end
        ip++;
        if (ne) exp_o.push_back(src_o[k]);
      end
    end
  endtask

  task automatic gen_random(input int fibers);
    src_o = {};
    src_i = {};
    for (int f = 0; f < fibers; f++) begin
      int n;
      src_o.push_back({1'b0, 16'(f + 100)});
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) src_i.push_back({1'b0, 16'($urandom)});
      src_i.push_back({1'b1, 8'h00, 8'($urandom_range(0, 2))});
      if ($urandom_range(0, 3) == 0) src_o.push_back(S0);
    end
    src_o.push_back(S0);
    src_o.push_back(DONE);
    src_i.push_back(DONE);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    crd_in_outer_valid = 1'b0;
    crd_in_inner_valid = 1'b0;
    crd_out_outer_ready = 1'b1;
    crd_out_inner_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    crd_in_outer_valid = 1'b0;
    crd_in_inner_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives both input streams and scores both output streams until all queues drain.
  task automatic run(input int max_cyc, input bit rnd, input int stop_after, input int done_hold);
    int gap_o, gap_i, st_o, st_i, hold;
    logic [16:0] t;
    gap_o = 0; gap_i = 0; st_o = 0; st_i = 0; hold = done_hold;
    done_cyc_o = -1; done_cyc_i = -1; first_in_i = -1; first_out_i = -1;
    bubbles_i = 0; early_done = 0; xfers = 0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      last_cycles = cyc + 1;
      crd_in_outer_valid = (src_o.size() > 0) && (gap_o == 0);
      crd_in_outer = (src_o.size() > 0) ? src_o[0] : 17'h0;
      crd_in_inner = (src_i.size() > 0) ? src_i[0] : 17'h0;
      if (src_o.size() > 0 && src_o[0] == DONE && src_i.size() > 0 && src_i[0] == DONE && hold > 0) begin
        hold--;
        crd_in_inner_valid = 1'b0;
      end else crd_in_inner_valid = (src_i.size() > 0) && (gap_i == 0);
      if (rnd) begin
        crd_out_outer_ready = (st_o == 0);
        if (st_o > 0) st_o--; else if ($urandom_range(0, 2) == 0) st_o = $urandom_range(1, 3);
        crd_out_inner_ready = (st_i == 0);
        if (st_i > 0) st_i--; else if ($urandom_range(0, 2) == 0) st_i = $urandom_range(1, 3);
      end else begin
        crd_out_outer_ready = 1'b1;
        crd_out_inner_ready = 1'b1;
      end
      #1;
      if (crd_in_outer_valid && crd_in_outer_ready) begin
        if (crd_in_outer == DONE && !crd_in_inner_valid) early_done++;
        void'(src_o.pop_front());
        xfers++;
        if (rnd) gap_o = $urandom_range(0, 1);
      end else if (gap_o > 0) gap_o--;
      if (crd_in_inner_valid && crd_in_inner_ready) begin
        if (first_in_i < 0) first_in_i = cyc;
        void'(src_i.pop_front());
        xfers++;
        if (rnd) gap_i = $urandom_range(0, 1);
      end else begin
        if (crd_in_inner_valid && !crd_in_inner[16] && first_in_i >= 0) bubbles_i++;
        if (gap_i > 0) gap_i--;
      end
      if (crd_out_outer_valid && crd_out_outer_ready) begin
        checks++;
        if (exp_o.size() == 0) begin
          errors++;
          $display("FAIL outer_extra: got %h, expected no token", crd_out_outer);
        end else begin
          t = exp_o.pop_front();
          if (crd_out_outer !== t) begin
            errors++;
            $display("FAIL outer_token: got %h, expected %h", crd_out_outer, t);
          end
        end
        if (crd_out_outer == DONE) done_cyc_o = cyc;
      end
      if (crd_out_inner_valid && crd_out_inner_ready) begin
        checks++;
        if (first_out_i < 0) first_out_i = cyc;
        if (exp_i.size() == 0) begin
          errors++;
          $display("FAIL inner_extra: got %h, expected no token", crd_out_inner);
        end else begin
          t = exp_i.pop_front();
          if (crd_out_inner !== t) begin
            errors++;
            $display("FAIL inner_token: got %h, expected %h", crd_out_inner, t);
          end
        end
        if (crd_out_inner == DONE) done_cyc_i = cyc;
      end
      if (stop_after > 0 && xfers >= stop_after) return;
      if (src_o.size() == 0 && src_i.size() == 0 && exp_o.size() == 0 && exp_i.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL run_timeout: got %0d/%0d outer/inner tokens left, expected 0/0", exp_o.size(), exp_i.size());
  endtask

  task automatic check_quiet(input string name);
    idle_inputs();
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if ({crd_out_outer_valid, crd_out_inner_valid} !== 2'b00) begin
      errors++;
      $display("FAIL %s_quiet: got valids %b, expected 00", name, {crd_out_outer_valid, crd_out_inner_valid});
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    crd_in_outer = 17'd3; crd_in_outer_valid = 1'b1;
    crd_in_inner = 17'd4; crd_in_inner_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({crd_in_outer_ready, crd_in_inner_ready, crd_out_outer_valid, crd_out_inner_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state: got %b, expected 0000",
               {crd_in_outer_ready, crd_in_inner_ready, crd_out_outer_valid, crd_out_inner_valid});
    end
    crd_in_outer_valid = 1'b0;
    crd_in_inner_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({crd_in_outer_ready, crd_in_inner_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release_ready: got %b, expected 10", {crd_in_outer_ready, crd_in_inner_ready});
    end
  endtask

  task automatic test_tile_en();
    @(negedge clk);
    tile_en = 1'b0;
    crd_in_outer = S0; crd_in_outer_valid = 1'b1;
    crd_in_inner = 17'd7; crd_in_inner_valid = 1'b1;
    #1;
    checks++;
    if ({crd_in_outer_ready, crd_in_inner_ready, crd_out_outer_valid, crd_out_inner_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL tile_en_off: got %b, expected 0000",
               {crd_in_outer_ready, crd_in_inner_ready, crd_out_outer_valid, crd_out_inner_valid});
    end
    @(negedge clk);
    crd_in_outer_valid = 1'b0;
    crd_in_inner_valid = 1'b0;
    tile_en = 1'b1;
  endtask

  task automatic test_clk_en_flush();
    do_reset();
    crd_out_outer_ready = 1'b0; crd_out_inner_ready = 1'b0;
    crd_in_outer = 17'd5; crd_in_outer_valid = 1'b1;
    crd_in_inner = 17'd9; crd_in_inner_valid = 1'b1;
    #1;
    checks++;
    if (crd_in_inner_ready !== 1'b1) begin
      errors++;
      $display("FAIL inner_data_ready: got %b, expected 1", crd_in_inner_ready);
    end
    @(negedge clk);
    crd_in_inner_valid = 1'b0;
    clk_en = 1'b0;
    #1;
    checks++;
    if ({crd_out_inner_valid, crd_in_outer_ready} !== 2'b00) begin
      errors++;
      $display("FAIL clk_en_off: got %b, expected 00", {crd_out_inner_valid, crd_in_outer_ready});
    end
    @(negedge clk);
    clk_en = 1'b1;
    #1;
    checks++;
    if ({crd_out_inner_valid, crd_out_inner, crd_out_outer_valid} !== {1'b1, 17'd9, 1'b0}) begin
      errors++;
      $display("FAIL clk_en_resume: got %b/%h/%b, expected 1/00009/0",
               crd_out_inner_valid, crd_out_inner, crd_out_outer_valid);
    end
    @(negedge clk);
    flush = 1'b1;
    crd_in_outer_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({crd_out_inner_valid, crd_in_outer_ready} !== 2'b00) begin
      errors++;
      $display("FAIL flush_clear: got %b, expected 00", {crd_out_inner_valid, crd_in_outer_ready});
    end
    flush = 1'b0;
    crd_out_outer_ready = 1'b1; crd_out_inner_ready = 1'b1;
  endtask

  task automatic load_basic();
    src_o = {17'd0, 17'd1, S0, DONE};
    src_i = {17'd5, S0, S1, DONE};
    build_expected();
  endtask

  task automatic test_basic();
    load_basic();
    run(200, 1'b0, 0, 0);
    check_quiet("basic");
  endtask

  task automatic test_no_drops();
    src_o = {17'd3, 17'd7, 17'd9, S0, DONE};
    src_i = {17'd1, S0, 17'd2, S0, 17'd4, S1, DONE};
    build_expected();
    run(200, 1'b0, 0, 0);
    check_quiet("no_drops");
  endtask

  task automatic test_all_empty();
    src_o = {17'd2, 17'd4, 17'd6, S0, DONE};
    src_i = {S0, S0, S1, DONE};
    build_expected();
    run(200, 1'b0, 0, 0);
    check_quiet("all_empty");
  endtask

  task automatic test_back_to_back();
    src_o = {17'd1, S0, DONE};
    src_i = {17'd10, 17'd11, 17'd12, 17'd13, 17'd14, 17'd15, 17'd16, 17'd17, S0, DONE};
    build_expected();
    run(200, 1'b0, 0, 0);
    checks++;
    if (bubbles_i !== 0) begin
      errors++;
      $display("FAIL throughput_bubbles: got %0d, expected 0", bubbles_i);
    end
    checks++;
    if (first_out_i - first_in_i !== 1) begin
      errors++;
      $display("FAIL latency: got %0d, expected 1", first_out_i - first_in_i);
    end
    check_quiet("back_to_back");
  endtask

  task automatic test_random_stalls();
    int total;
    total = 0;
    for (int s = 0; s < 30 && total < 4000; s++) begin
      gen_random(60);
      build_expected();
      run(5000, 1'b1, 0, 0);
      total += last_cycles;
      idle_inputs();
    end
    check_quiet("random");
  endtask

  task automatic test_mid_reset();
    load_basic();
    run(200, 1'b0, 3, 0);
    @(negedge clk);
    rst = 1'b1;
    crd_in_outer_valid = 1'b0;
    crd_in_inner_valid = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({crd_out_outer_valid, crd_out_inner_valid, crd_in_outer_ready, crd_in_inner_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_clear: got %b, expected 0000",
               {crd_out_outer_valid, crd_out_inner_valid, crd_in_outer_ready, crd_in_inner_ready});
    end
    rst = 1'b0;
    load_basic();
    run(200, 1'b0, 0, 0);
    check_quiet("mid_reset");
  endtask

  task automatic test_done_skew();
    load_basic();
    run(300, 1'b0, 0, 10);
    checks++;
    if (early_done !== 0) begin
      errors++;
      $display("FAIL done_held: got %0d early pops, expected 0", early_done);
    end
    checks++;
    if (done_cyc_o < 0 || done_cyc_o !== done_cyc_i) begin
      errors++;
      $display("FAIL done_together: got cycles %0d/%0d, expected equal", done_cyc_o, done_cyc_i);
    end
    check_quiet("done_skew");
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
    crd_in_outer = 17'h0; crd_in_outer_valid = 1'b0;
    crd_in_inner = 17'h0; crd_in_inner_valid = 1'b0;
    crd_out_outer_ready = 1'b1; crd_out_inner_ready = 1'b1;
    test_reset();
    test_tile_en();
    test_clk_en_flush();
    do_reset();
    test_basic();
    test_no_drops();
    test_all_empty();
    test_back_to_back();
    test_done_skew();
    test_mid_reset();
    test_random_stalls();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crd_drop_unit.md
CRD_DROP_UNIT -- requirements
Module: crd_drop_unit

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL expose ports: clk  in  1  clock (all logic on rising edge).
REQ-003 SHALL expose: rst  in  1  synchronous active-high reset.
REQ-004 SHALL expose: clk_en  in  1  global clock enable; when 0, no state, FIFO or handshake advances.
REQ-005 SHALL expose: flush  in  1  synchronous active-high soft clear, same effect as rst.
REQ-006 SHALL expose: tile_en  in  1  tile enable; when 0, all ready and valid outputs are 0.
REQ-007 SHALL expose: crd_in_outer / _valid / _ready  in/in/out  17/1/1  outer coordinate stream from the intersect stage's coord_out.
REQ-008 SHALL expose: crd_in_inner / _valid / _ready  in/in/out  17/1/1  inner coordinate stream.
REQ-009 SHALL expose: crd_out_outer / _valid / _ready  out/out/in  17/1/1  filtered outer stream.
REQ-010 SHALL expose: crd_out_inner / _valid / _ready  out/out/in  17/1/1  inner stream passthrough.

Function
REQ-011 Token format SHALL be: bit16=0 data (bits15:0 coordinate); bit16=1 control; 17'h10100 = DONE; other controls = stop token Sn with level n in bits7:0.
REQ-012 Each outer data coordinate SHALL pair with exactly one inner stop token (any level) closing its inner fiber.
REQ-013 Outer data coordinate SHALL be emitted only if its inner fiber contained at least one data token, otherwise dropped.
REQ-014 Outer stop tokens SHALL be forwarded unchanged and SHALL NOT consume an inner token.
REQ-015 Every inner token SHALL be forwarded unchanged, in order, on crd_out_inner.
REQ-016 Transfer SHALL occur when valid && ready on the same clk edge with clk_en=1; a transfer consumes exactly one token.
REQ-017 FSM states SHALL be IDLE, PROC, DONE.
- IDLE -> PROC: tile_en=1 and any input valid.
- PROC -> DONE: outer head DONE and inner head DONE.
- DONE: emit DONE once on each output; -> IDLE when both accepted.
REQ-018 In PROC the outer head SHALL be held (not popped) while its inner fiber streams; a nonempty flag SHALL set on each inner data transfer.
REQ-019 On the inner stop transfer, the outer head SHALL be popped that cycle; if nonempty=1 it SHALL be pushed to the outer output FIFO; nonempty SHALL clear.
REQ-020 When the outer head is a stop token, it SHALL be popped and pushed in one cycle, with no inner-side action that cycle.
REQ-021 Inner data arriving while outer head is not yet valid SHALL stall (crd_in_inner_ready=0).
REQ-022 DONE on one input alone SHALL be held without popping until the other input also presents DONE.
REQ-023 Each output SHALL be fed through a 2-entry FIFO; input ready SHALL deassert when the target FIFO is full, and also while the other FIFO is full if the cycle pushes both.
REQ-024 Latency input-transfer to output-valid SHALL be 1 cycle; sustained throughput SHALL be 1 inner token per cycle with both outputs ready.
REQ-025 Output backpressure SHALL never drop or duplicate tokens.

Reset
REQ-026 On rst or flush: state=IDLE, nonempty=0, FIFOs empty, all *_valid=0, all *_ready=0 the following cycle.
REQ-027 rst asserted mid-stream SHALL discard all in-flight tokens; no partial token SHALL appear after release.
REQ-028 Inputs SHALL become ready again the first cycle after rst and flush both deassert with tile_en=1.

Structure
REQ-029 Shared package SHALL hold token width (17), DONE encoding 17'h10100, control-bit index, stop-level field, and the FSM state enum.
REQ-030 Output buffering SHALL be one reused sub-module, reg_fifo_2 (2-deep, ready/valid), instantiated twice.

Verification
REQ-031 outer 0,1,S0,DONE; inner 5,S0,S1,DONE -> outer out 0,S0,DONE; inner out identical to input.
REQ-032 outer 3,7,9,S0,DONE; inner 1,S0,2,S0,4,S1,DONE -> outer out 3,7,9,S0,DONE (no drops).
REQ-033 all inner fibers empty (inner S0,S0,S1,DONE for outer 2,4,6,S0,DONE) -> outer out S0,DONE.
REQ-034 random 0-3 cycle ready stalls on both outputs, 4000 cycles -> output streams match golden files exactly, no duplicates.
REQ-035 rst pulsed mid-fiber after 3 transfers -> all valids 0 next cycle; rerun REQ-031 stimulus yields REQ-031 output.
REQ-036 outer DONE arrives 10 cycles before inner DONE -> outer DONE held; single DONE emitted on each output together.
